// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, op encoding and FSM state type for the register-file copy engine
package regfile_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/regfile_copy_engine.sv
// regfile_copy_engine: copies or fills a range of register-file entries with a one-cycle read-to-write pipeline
module regfile_copy_engine
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    input  logic [AW:0]      length,
    input  logic [WIDTH-1:0] fill_value,
    output logic             busy,
    output logic             done,
    output logic             rf_read_en,
    output logic [AW-1:0]    rf_addr_read,
    input  logic [WIDTH-1:0] rf_data_out,
    output logic             rf_write_en,
    output logic [AW-1:0]    rf_addr_write,
    output logic [WIDTH-1:0] rf_data_in
);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] fill_q;
    logic [AW-1:0]    wr_next;
    logic [AW:0]      left;
    logic [AW:0]      len_c;
    logic             more_wr;

    // left counts reads still to issue (COPY) or writes still to issue (FILL)
    assign len_c   = (length > DEPTH_L) ? DEPTH_L : length;
    assign more_wr = (op_q == OP_COPY) ? rf_read_en : (left != '0);

    // command FSM; every port output is registered and describes the coming cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= OP_COPY;
            fill_q        <= '0;
            wr_next       <= '0;
            left          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rf_read_en    <= 1'b0;
            rf_addr_read  <= '0;
            rf_write_en   <= 1'b0;
            rf_addr_write <= '0;
            rf_data_in    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        fill_q <= fill_value;
                        left   <= len_c - 1'b1;
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            if (op == OP_COPY) begin
                                rf_read_en   <= 1'b1;
                                rf_addr_read <= src_base;
                                wr_next      <= dst_base;
                            end else begin
                                rf_write_en   <= 1'b1;
                                rf_addr_write <= dst_base;
                                rf_data_in    <= fill_value;
                                wr_next       <= dst_base + 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    rf_read_en  <= (op_q == OP_COPY) && (left != '0);
                    rf_write_en <= more_wr;
                    if (left != '0) begin
                        left <= left - 1'b1;
                        if (op_q == OP_COPY) rf_addr_read <= rf_addr_read + 1'b1;
                    end
                    if (more_wr) begin
                        rf_addr_write <= wr_next;
                        wr_next       <= wr_next + 1'b1;
                        rf_data_in    <= (op_q == OP_COPY) ? rf_data_out : fill_q;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_copy_engine.sv
// tb_regfile_copy_engine: scoreboard bench driving the copy engine against a behavioural register file
module tb_regfile_copy_engine;
    import regfile_pkg::*;
    localparam int W = 4;
    localparam int D = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   length = '0;
    logic [W-1:0]  fill_value = '0;
    logic          busy, done, rf_read_en, rf_write_en;
    logic [AW-1:0] rf_addr_read, rf_addr_write;
    logic [W-1:0]  rf_data_out, rf_data_in;

    always #5 clk = ~clk;

    regfile_copy_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_base(src_base),
        .dst_base(dst_base), .length(length), .fill_value(fill_value),
        .busy(busy), .done(done), .rf_read_en(rf_read_en), .rf_addr_read(rf_addr_read),
        .rf_data_out(rf_data_out), .rf_write_en(rf_write_en),
        .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in)
    );

    // behavioural register file: combinational read, write captured on the rising edge, plus a preload port
    logic [W-1:0]  mem [D];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [W-1:0]  tb_data = '0;
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_addr_write] <= rf_data_in;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end
    assign rf_data_out = mem[rf_addr_read];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} xact_t;
    xact_t        wr_q[$];
    xact_t        rd_q[$];
    xact_t        ew, er;
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] pl [D];

    // scoreboard: every strobe must match the next expected transaction
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_write_en) begin
                check("wr_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(rf_addr_write), 32'(ew.a));
                    check("wr_data", 32'(rf_data_in), 32'(ew.d));
                end
            end
            if (rf_read_en) begin
                check("rd_expected", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    er = rd_q.pop_front();
                    check("rd_addr", 32'(rf_addr_read), 32'(er.a));
                    check("rd_data", 32'(rf_data_out), 32'(er.d));
                end
            end
        end
    end

    // reference: write i lands before read i+2, so read i sees writes 0..i-2 only
    task automatic model(input logic o, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                         input logic [AW:0] len, input logic [W-1:0] f, output int lc);
        logic [W-1:0] wv [D];
        int ap = 0;
        lc = (int'(len) > D) ? D : int'(len);
        for (int i = 0; i < lc; i++) begin
            if (o == OP_COPY) begin
                while (ap <= i - 2) begin
                    ref_mem[AW'(int'(dd) + ap)] = wv[ap];
                    ap++;
                end
                wv[i] = ref_mem[AW'(int'(s) + i)];
                rd_q.push_back(xact_t'{a: AW'(int'(s) + i), d: wv[i]});
            end else begin
                wv[i] = f;
            end
            wr_q.push_back(xact_t'{a: AW'(int'(dd) + i), d: wv[i]});
        end
        while (ap < lc) begin
            ref_mem[AW'(int'(dd) + ap)] = wv[ap];
            ap++;
        end
    endtask

    task automatic preload();
        for (int i = 0; i < D; i++) begin
            tb_we = 1'b1;
            tb_addr = AW'(i);
            tb_data = pl[i];
            ref_mem[i] = pl[i];
            @(negedge clk);
        end
        tb_we = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < D; i++) check($sformatf("%s_mem%0d", name, i), 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    // issue one command at a negedge; pc>0 re-pulses start with junk operands in that cycle
    task automatic run_cmd(input string name, input logic o, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                           input logic [AW:0] len, input logic [W-1:0] f, input int pc);
        int lc, exp_done, exp_busy;
        int nb = 0;
        int nd = 0;
        int dc = 0;
        model(o, s, dd, len, f, lc);
        exp_done = (lc == 0) ? 1 : ((o == OP_COPY) ? lc + 2 : lc + 1);
        exp_busy = (lc == 0) ? 0 : exp_done - 1;
        op = o; src_base = s; dst_base = dd; length = len; fill_value = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o;
        src_base = AW'($urandom);
        dst_base = AW'($urandom);
        length = (AW+1)'($urandom);
        fill_value = W'($urandom);
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (dc == 0) dc = c;
            end
            start = (pc == c);
        end
        start = 1'b0;
        check({name, "_done_cycle"}, 32'(dc), 32'(exp_done));
        check({name, "_done_pulses"}, 32'(nd), 1);
        check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({name, "_writes_left"}, 32'(wr_q.size()), 0);
        check({name, "_reads_left"}, 32'(rd_q.size()), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(rf_read_en), 0);
        check("rst_wr_en", 32'(rf_write_en), 0);
        check("rst_rd_addr", 32'(rf_addr_read), 0);
        check("rst_wr_addr", 32'(rf_addr_write), 0);
        check("rst_wr_data", 32'(rf_data_in), 0);
        rst = 1'b0;
        @(negedge clk);

        pl = '{4'd0, 4'd0, 4'd0, 4'd10, 4'd12, 4'd0, 4'd0, 4'd0};
        preload();
        run_cmd("copy", OP_COPY, 3'd3, 3'd6, 4'd2, 4'd0, 0);
        check_mem("copy");
        check("copy_m6", 32'(mem[6]), 32'd10);
        check("copy_m7", 32'(mem[7]), 32'd12);

        run_cmd("fill", OP_FILL, 3'd0, 3'd0, 4'd8, 4'd15, 2);
        check_mem("fill");

        pl = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
        preload();
        run_cmd("wrap", OP_COPY, 3'd6, 3'd0, 4'd4, 4'd0, 0);
        check_mem("wrap");

        pl = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
        preload();
        run_cmd("ovl", OP_COPY, 3'd2, 3'd3, 4'd3, 4'd0, 0);
        check_mem("ovl");
        check("ovl_m3", 32'(mem[3]), 32'd1);
        check("ovl_m4", 32'(mem[4]), 32'd2);
        check("ovl_m5", 32'(mem[5]), 32'd3);

        run_cmd("len0", OP_COPY, 3'd1, 3'd2, 4'd0, 4'd0, 1);
        check_mem("len0");

        run_cmd("clamp", OP_FILL, 3'd0, 3'd2, 4'd12, 4'd3, 0);
        check_mem("clamp");

        pl = '{default: 4'd0};
        preload();
        op = OP_FILL; src_base = '0; dst_base = '0; length = 4'd8; fill_value = 4'd9; start = 1'b1;
        wr_q.push_back(xact_t'{a: 3'd0, d: 4'd9});
        ref_mem[0] = 4'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_wr_en", 32'(rf_write_en), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_done", 32'(done), 0);
            check("abort_wr_en_hold", 32'(rf_write_en), 0);
        end
        check("abort_writes_left", 32'(wr_q.size()), 0);
        check("abort_m0", 32'(mem[0]), 32'd9);
        check("abort_m1", 32'(mem[1]), 32'd0);
        rst = 1'b0;
        run_cmd("post_rst", OP_COPY, 3'd0, 3'd4, 4'd2, 4'd0, 0);
        check_mem("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
